// File: rtl/bp_common_cfg_pkg.sv
// Shared configuration-bus types: loader state, register map and bus payload.
package bp_common_cfg_pkg;

  localparam int unsigned cfg_core_width_gp = 8;
  localparam int unsigned cfg_addr_width_gp = 16;
  localparam int unsigned cfg_data_width_gp = 64;

  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_freeze_gp   = 16'h0001;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_core_id_gp  = 16'h0002;
  localparam logic [cfg_addr_width_gp-1:0] bp_cfg_reg_cce_mode_gp = 16'h0003;

  typedef enum logic [1:0] {
    e_idle,
    e_config,
    e_unfreeze,
    e_done
  } bp_cfg_loader_state_e;

  typedef struct packed {
    logic                         v;
    logic                         w;
    logic [cfg_core_width_gp-1:0] core;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_bus_s;

endpackage

// File: rtl/bp_cfg_seq_gen.sv
// Maps the loader's sequencing position to the bus request it must issue.
module bp_cfg_seq_gen
  import bp_common_cfg_pkg::*;
#(
  parameter int unsigned core_cnt_width_p = 1
) (
  input  bp_cfg_loader_state_e        state_i,
  input  logic [core_cnt_width_p-1:0] core_cnt_i,
  input  logic [1:0]                  reg_cnt_i,
  input  logic                        mode_i,
  output bp_cfg_bus_s                 req_o
);

  always_comb begin
    req_o = '0;
    unique case (state_i)
      e_config: begin
        req_o.v    = 1'b1;
        req_o.w    = 1'b1;
        req_o.core = cfg_core_width_gp'(core_cnt_i);
        unique case (reg_cnt_i)
          2'd0: begin
            req_o.addr = bp_cfg_reg_freeze_gp;
            req_o.data = cfg_data_width_gp'(1);
          end
          2'd1: begin
            req_o.addr = bp_cfg_reg_core_id_gp;
            req_o.data = cfg_data_width_gp'(core_cnt_i);
          end
          default: begin
            req_o.addr = bp_cfg_reg_cce_mode_gp;
            req_o.data = cfg_data_width_gp'(mode_i);
          end
        endcase
      end
      e_unfreeze: begin
        req_o.v    = 1'b1;
        req_o.w    = 1'b1;
        req_o.core = cfg_core_width_gp'(core_cnt_i);
        req_o.addr = bp_cfg_reg_freeze_gp;
        req_o.data = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: freezes, numbers and moded every core, then unfreezes them;
// the host port owns the bus whenever the loader is not busy.
module bp_cfg_loader
  import bp_common_cfg_pkg::*;
#(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned cfg_core_width_p = cfg_core_width_gp,
  parameter int unsigned cfg_addr_width_p = cfg_addr_width_gp,
  parameter int unsigned cfg_data_width_p = cfg_data_width_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        host_v_i,
  input  logic                        host_w_i,
  input  logic [cfg_core_width_p-1:0] host_core_i,
  input  logic [cfg_addr_width_p-1:0] host_addr_i,
  input  logic [cfg_data_width_p-1:0] host_data_i,
  output logic                        host_ready_o,
  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i
);

  localparam int unsigned core_cnt_width_lp = $clog2(num_core_p + 1);
  localparam logic [core_cnt_width_lp-1:0] last_core_lp = core_cnt_width_lp'(num_core_p - 1);

  bp_cfg_loader_state_e          state_q, state_d;
  logic [core_cnt_width_lp-1:0]  core_cnt_q, core_cnt_d;
  logic [1:0]                    reg_cnt_q, reg_cnt_d;
  logic                          mode_q, mode_d;
  logic                          last_reg_c, last_core_c;
  bp_cfg_bus_s                   req;

  assign last_reg_c  = (reg_cnt_q == 2'd2);
  assign last_core_c = (core_cnt_q == last_core_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle, e_done: if (start_i) state_d = e_config;
      e_config:       if (cfg_ready_i && last_reg_c && last_core_c) state_d = e_unfreeze;
      e_unfreeze:     if (cfg_ready_i && last_core_c) state_d = e_done;
      default:        state_d = e_idle;
    endcase
  end

  // Counters wrap back to zero at their terminal value so they never overrun.
  always_comb begin
    core_cnt_d = core_cnt_q;
    reg_cnt_d  = reg_cnt_q;
    mode_d     = mode_q;
    unique case (state_q)
      e_idle, e_done: begin
        if (start_i) begin
          mode_d     = cce_mode_i;
          core_cnt_d = '0;
          reg_cnt_d  = '0;
        end
      end
      e_config: begin
        if (cfg_ready_i) begin
          if (last_reg_c) begin
            reg_cnt_d  = '0;
            core_cnt_d = last_core_c ? '0 : core_cnt_q + core_cnt_width_lp'(1);
          end else begin
            reg_cnt_d = reg_cnt_q + 2'd1;
          end
        end
      end
      e_unfreeze: begin
        if (cfg_ready_i) core_cnt_d = last_core_c ? '0 : core_cnt_q + core_cnt_width_lp'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      core_cnt_q <= '0;
      reg_cnt_q  <= '0;
      mode_q     <= 1'b0;
    end else begin
      core_cnt_q <= core_cnt_d;
      reg_cnt_q  <= reg_cnt_d;
      mode_q     <= mode_d;
    end
  end

  bp_cfg_seq_gen #(
    .core_cnt_width_p(core_cnt_width_lp)
  ) seq_gen (
    .state_i   (state_q),
    .core_cnt_i(core_cnt_q),
    .reg_cnt_i (reg_cnt_q),
    .mode_i    (mode_q),
    .req_o     (req)
  );

  // Host passthrough while idle/done; reset masks the handshake outputs immediately.
  always_comb begin
    busy_o       = (state_q == e_config) || (state_q == e_unfreeze);
    done_o       = (state_q == e_done);
    cfg_v_o      = host_v_i;
    cfg_w_o      = host_w_i;
    cfg_core_o   = host_core_i;
    cfg_addr_o   = host_addr_i;
    cfg_data_o   = host_data_i;
    host_ready_o = cfg_ready_i;
    if (busy_o) begin
      cfg_v_o      = req.v;
      cfg_w_o      = req.w;
      cfg_core_o   = cfg_core_width_p'(req.core);
      cfg_addr_o   = cfg_addr_width_p'(req.addr);
      cfg_data_o   = cfg_data_width_p'(req.data);
      host_ready_o = 1'b0;
    end
    if (reset_i) begin
      cfg_v_o      = 1'b0;
      host_ready_o = 1'b0;
    end
  end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
Boot-time sequencer and owner of the shared configuration bus (cfg_core/addr/data widths from the processor parameter struct).
- After start_i, it walks every core and programs three registers in order: freeze=1, core_id=c, cce_mode.
- It then unfreezes every core in index order and signals done.
- While idle or done it arbitrates the bus to an external host port, so a debug/host agent shares the same link.

Parameters:
num_core_p, 1, number of cores to program (1..2^cfg_core_width_p)
cfg_core_width_p, 8, core select width
cfg_addr_width_p, 16, register address width
cfg_data_width_p, 64, register data width

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
start_i  in  1  one-cycle start pulse; ignored unless state is e_idle or e_done
cce_mode_i  in  1  value written to cce_mode register (sampled at start)
busy_o  out  1  loader owns bus (e_config or e_unfreeze)
done_o  out  1  high in e_done
host_v_i  in  1  host request valid
host_w_i  in  1  host write(1)/read(0)
host_core_i  in  cfg_core_width_p  host core select
host_addr_i  in  cfg_addr_width_p  host address
host_data_i  in  cfg_data_width_p  host data
host_ready_o  out  1  host request accepted when host_v_i & host_ready_o
cfg_v_o  out  1  bus request valid
cfg_w_o  out  1  bus write enable
cfg_core_o  out  cfg_core_width_p  target core
cfg_addr_o  out  cfg_addr_width_p  register address
cfg_data_o  out  cfg_data_width_p  write data
cfg_ready_i  in  1  bus ready; transfer on cfg_v_o & cfg_ready_i

Behaviour:
- Reset (async assert, any state): state=e_idle; core_cnt=0; reg_cnt=0; mode_r=0; busy_o=0; done_o=0; cfg_v_o=0; host_ready_o=0.
- States: e_idle, e_config, e_unfreeze, e_done.
- e_idle/e_done:
  - Bus is a combinational passthrough of the host: cfg_* = host_*, host_ready_o = cfg_ready_i.
  - start_i: latch mode_r = cce_mode_i; clear core_cnt and reg_cnt; go to e_config; done_o drops.
  - A host transfer in the same cycle as start_i completes normally; the loader takes the bus the next cycle.
- e_config: cfg_v_o=1, cfg_w_o=1, cfg_core_o=core_cnt, host_ready_o=0.
  - reg_cnt 0: addr=freeze_addr, data=1.
  - reg_cnt 1: addr=core_id_addr, data=core_cnt (zero-extended).
  - reg_cnt 2: addr=cce_mode_addr, data=mode_r.
  - On handshake: reg_cnt increments. At reg_cnt 2 it wraps to 0 and core_cnt increments.
  - After the handshake at core num_core_p-1, reg 2: core_cnt=0, go to e_unfreeze.
- e_unfreeze: cfg_v_o=1, cfg_w_o=1, addr=freeze_addr, data=0, core=core_cnt.
  - On handshake core_cnt increments.
  - After the last core: go to e_done.
- Stability: all cfg_* outputs are held unchanged while cfg_v_o & ~cfg_ready_i. No request is dropped or reordered.
- Latency (cfg_ready_i tied 1): start_i in cycle 0; first cfg_v_o in cycle 1; 4*num_core_p back-to-back transfers; done_o=1 in cycle 4*num_core_p+1.
- Counters: core_cnt is clog2(num_core_p+1) bits wide; reg_cnt is 2 bits; neither counts past its terminal value.
- Host traffic is never granted while busy_o=1; host_v_i is ignored there and has no side effects.

Decomposition:
- bp_common_cfg_pkg holds:
  - state enum bp_cfg_loader_state_e;
  - address constants bp_cfg_reg_freeze_gp=16'h0001, bp_cfg_reg_core_id_gp=16'h0002, bp_cfg_reg_cce_mode_gp=16'h0003;
  - a bp_cfg_bus_s struct (v, w, core, addr, data) parameterized by the cfg widths.
- One sub-module, bp_cfg_seq_gen: combinational map (state, core_cnt, reg_cnt, mode_r) -> request struct.
- The FSM, counters and host mux stay in the top level.

Test Plan:
- num_core_p=2, cfg_ready_i=1, start_i with cce_mode_i=1 -> exactly 8 writes:
  - (c0,0x1,1) (c0,0x2,0) (c0,0x3,1)
  - (c1,0x1,1) (c1,0x2,1) (c1,0x3,1)
  - (c0,0x1,0) (c1,0x1,0)
  - done_o=1 in cycle 9.
- Backpressure: cfg_ready_i low 3 cycles during the c1 core_id write -> outputs held at (c1,0x2,1) for those cycles, no duplicate or skipped write, done_o delayed by 3 cycles.
- Host arbitration: host_v_i=1 throughout a run -> host_ready_o=0 while busy_o=1; in e_done a host read (c1,0x10) appears on cfg_* the same cycle with host_ready_o=cfg_ready_i.
- Reset mid-run: assert reset_i asynchronously after the 4th transfer -> cfg_v_o=0 immediately, state e_idle; a new start_i restarts at (c0,0x1,1).
- Restart from e_done: start_i with cce_mode_i=0 -> done_o drops next cycle, full sequence reissued with cce_mode data 0.
- start_i while busy -> ignored; sequence and counts unchanged.
